arq_rx_ctrl: RTL and testbench

Receive-side ARQ sequencer placed after the demapper. It consumes the per-frame CRC verdict and the ARQ enable from the demapper. For each frame it tells the client TX AXIS FIFO to commit or discard the buffered payload. When a frame fails CRC and ARQ is enabled, it runs a bounded request/ack/timeout retransmission loop toward the rec_tran block.

---
 rtl/arq_rx_ctrl_if.sv | 31 +++
 rtl/arq_rx_ctrl.sv | 127 ++++++++++++
 tb/tb_arq_rx_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/arq_rx_ctrl_if.sv
// Handshake bundle between the demapper/rec_tran/client FIFO side and the
// receive-side ARQ sequencer. The sequencer uses the slave view; whoever
// drives verdicts and acks uses the master view.
interface arq_rx_ctrl_if #(
  parameter int RETRY_W = 4
);
  logic               i_crc_err;
  logic               i_crc_err_valid;
  logic               i_arq_en;
  logic               i_arq_en_valid;
  logic               i_retrans_ack;
  logic               o_retrans_req;
  logic               o_frame_commit;
  logic               o_frame_discard;
  logic               o_fail;
  logic               o_busy;
  logic [RETRY_W-1:0] o_retry_cnt;
  logic [15:0]        o_err_frame_cnt;

  modport master (
    output i_crc_err, i_crc_err_valid, i_arq_en, i_arq_en_valid, i_retrans_ack,
    input  o_retrans_req, o_frame_commit, o_frame_discard, o_fail, o_busy,
           o_retry_cnt, o_err_frame_cnt
  );

  modport slave (
    input  i_crc_err, i_crc_err_valid, i_arq_en, i_arq_en_valid, i_retrans_ack,
    output o_retrans_req, o_frame_commit, o_frame_discard, o_fail, o_busy,
           o_retry_cnt, o_err_frame_cnt
  );
endinterface

// File: rtl/arq_rx_ctrl.sv
// Receive-side ARQ sequencer. Turns each frame's CRC verdict into a commit or
// discard for the client FIFO and, for failed frames with ARQ enabled, runs a
// bounded request / ack / timeout retransmission loop. All outputs registered.
module arq_rx_ctrl #(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 20000,
  parameter int RETRY_W   = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  arq_rx_ctrl_if.slave  bus
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic               arq_en_q;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [15:0]        err_cnt_q;
  logic               commit_q, discard_q, fail_q, req_q, busy_q;
  logic               commit_d, discard_d, fail_d;

  // A same-cycle enable update takes effect for the verdict in that cycle.
  logic arq_eff, verdict, bad, good, tmo_exp, retry_max;
  assign arq_eff   = bus.i_arq_en_valid ? bus.i_arq_en : arq_en_q;
  assign verdict   = bus.i_crc_err_valid;
  assign bad       = verdict & bus.i_crc_err;
  assign good      = verdict & ~bus.i_crc_err;
  assign tmo_exp   = (state_q == S_WAIT) && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign retry_max = (retry_q == RETRY_W'(MAX_RETRY));

  // State register; reset drops the loop immediately.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a verdict in WAIT always takes priority over timeout expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bad && arq_eff) state_d = S_REQ;
      S_REQ:  if (bus.i_retrans_ack) state_d = S_WAIT;
      S_WAIT: begin
        if (good)                      state_d = S_IDLE;
        else if (bad || tmo_exp)       state_d = retry_max ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: pulses, retry count and timeout counter for the next cycle.
  always_comb begin
    commit_d  = 1'b0;
    discard_d = 1'b0;
    fail_d    = 1'b0;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (good) commit_d = 1'b1;
        if (bad) begin
          discard_d = 1'b1;
          if (arq_eff) retry_d = RETRY_W'(1);
        end
      end
      S_REQ: begin
        // Verdicts arriving while a request is outstanding belong to stale frames.
        if (verdict) discard_d = 1'b1;
        if (bus.i_retrans_ack) tmo_d = '0;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (good) begin
          commit_d = 1'b1;
          retry_d  = '0;
        end else if (bad || tmo_exp) begin
          discard_d = bad;
          if (retry_max) begin
            fail_d  = 1'b1;
            retry_d = '0;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
      end
      default: retry_d = '0;
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      arq_en_q  <= 1'b0;
      tmo_q     <= '0;
      retry_q   <= '0;
      err_cnt_q <= '0;
      commit_q  <= 1'b0;
      discard_q <= 1'b0;
      fail_q    <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (bus.i_arq_en_valid) arq_en_q <= bus.i_arq_en;
      if (bad && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      commit_q  <= commit_d;
      discard_q <= discard_d;
      fail_q    <= fail_d;
      req_q     <= (state_d == S_REQ);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign bus.o_retrans_req   = req_q;
  assign bus.o_frame_commit  = commit_q;
  assign bus.o_frame_discard = discard_q;
  assign bus.o_fail          = fail_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_retry_cnt     = retry_q;
  assign bus.o_err_frame_cnt = err_cnt_q;

endmodule

// File: tb/tb_arq_rx_ctrl.sv
// Bench for arq_rx_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the sequencer's rules.
module tb_arq_rx_ctrl;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 16;
  localparam int RETRY_W   = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  arq_rx_ctrl_if #(.RETRY_W(RETRY_W)) bus();

  arq_rx_ctrl #(
    .MAX_RETRY(MAX_RETRY),
    .TIMEOUT  (TIMEOUT),
    .RETRY_W  (RETRY_W)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: frame-level view of the retransmission loop.
  bit m_arq, m_active, m_asking;
  int m_tries, m_elapsed, m_errs;
  bit e_commit, e_discard, e_fail;

  // Observation tallies for the directed scenarios.
  int c_commit, c_discard, c_fail, c_req_rise, c_req_hi, max_retry_seen;
  bit prev_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit err, input bit v, input bit arq, input bit arqv, input bit ack);
    bus.i_crc_err       = err;
    bus.i_crc_err_valid = v;
    bus.i_arq_en        = arq;
    bus.i_arq_en_valid  = arqv;
    bus.i_retrans_ack   = ack;
  endtask

  task automatic model_reset();
    m_arq = 0; m_active = 0; m_asking = 0;
    m_tries = 0; m_elapsed = 0; m_errs = 0;
    e_commit = 0; e_discard = 0; e_fail = 0;
  endtask

  task automatic clr_tally();
    c_commit = 0; c_discard = 0; c_fail = 0; c_req_rise = 0; c_req_hi = 0;
    max_retry_seen = 0; prev_req = 0;
  endtask

  // Apply the rules for one clock using the inputs currently driven.
  task automatic model_step();
    bit arq_now, v, err, ack, expired;
    v = bus.i_crc_err_valid; err = bus.i_crc_err; ack = bus.i_retrans_ack;
    arq_now = bus.i_arq_en_valid ? bus.i_arq_en : m_arq;
    e_commit = 0; e_discard = 0; e_fail = 0;
    if (v && err && m_errs < 65535) m_errs++;
    if (!m_active) begin
      if (v && !err) e_commit = 1;
      if (v && err) begin
        e_discard = 1;
        if (arq_now) begin m_active = 1; m_asking = 1; m_tries = 1; end
      end
    end else if (m_asking) begin
      if (v) e_discard = 1;
      if (ack) begin m_asking = 0; m_elapsed = 0; end
    end else begin
      expired = (m_elapsed == TIMEOUT - 1);
      m_elapsed++;
      if (v && !err) begin
        e_commit = 1; m_active = 0; m_tries = 0;
      end else if (v || expired) begin
        if (v) e_discard = 1;
        if (m_tries == MAX_RETRY) begin e_fail = 1; m_active = 0; m_tries = 0; end
        else begin m_tries++; m_asking = 1; end
      end
    end
    if (bus.i_arq_en_valid) m_arq = bus.i_arq_en;
  endtask

  task automatic cycle();
    model_step();
    @(posedge i_clk);
    #1;
    chk("commit",  bus.o_frame_commit,  e_commit);
    chk("discard", bus.o_frame_discard, e_discard);
    chk("fail",    bus.o_fail,          e_fail);
    chk("req",     bus.o_retrans_req,   m_active && m_asking);
    chk("busy",    bus.o_busy,          m_active);
    chk("retry",   bus.o_retry_cnt,     m_tries);
    chk("errcnt",  bus.o_err_frame_cnt, m_errs);
    chk("excl",    bus.o_frame_commit & bus.o_frame_discard, 0);
    c_commit  += bus.o_frame_commit;
    c_discard += bus.o_frame_discard;
    c_fail    += bus.o_fail;
    c_req_hi  += bus.o_retrans_req;
    if (bus.o_retrans_req && !prev_req) c_req_rise++;
    prev_req = bus.o_retrans_req;
    if (int'(bus.o_retry_cnt) > max_retry_seen) max_retry_seen = bus.o_retry_cnt;
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, ack);
      cycle();
    end
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0);
    i_rst = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    chk("rst_req",    bus.o_retrans_req,   0);
    chk("rst_busy",   bus.o_busy,          0);
    chk("rst_retry",  bus.o_retry_cnt,     0);
    chk("rst_errcnt", bus.o_err_frame_cnt, 0);
    chk("rst_pulses", {bus.o_frame_commit, bus.o_frame_discard, bus.o_fail}, 0);
    i_rst = 1'b1;
    clr_tally();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    clr_tally();

    // 1: three good frames
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0); cycle();
      chk("t1_commit_now", bus.o_frame_commit, 1);
      idle(2, 0);
    end
    chk("t1_commits", c_commit, 3);
    chk("t1_busy_seen", c_req_hi, 0);
    chk("t1_errcnt", bus.o_err_frame_cnt, 0);

    // 2: bad frame with ARQ off
    apply_reset();
    drive(1, 1, 0, 0, 0); cycle();
    idle(5, 1);
    chk("t2_discards", c_discard, 1);
    chk("t2_req_seen", c_req_hi, 0);
    chk("t2_errcnt", bus.o_err_frame_cnt, 1);
    chk("t2_busy", bus.o_busy, 0);

    // 3: ARQ on, bad frame, late ack, then good frame
    apply_reset();
    drive(1, 1, 1, 1, 0); cycle();
    chk("t3_retry1", bus.o_retry_cnt, 1);
    idle(5, 0);
    idle(1, 1);
    idle(2, 0);
    drive(0, 1, 0, 0, 0); cycle();
    idle(1, 0);
    chk("t3_discards", c_discard, 1);
    chk("t3_req_cycles", c_req_hi, 6);
    chk("t3_commits", c_commit, 1);
    chk("t3_retry0", bus.o_retry_cnt, 0);

    // 4: four bad frames with immediate acks
    apply_reset();
    drive(0, 0, 1, 1, 0); cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 0); cycle();
      if (k < 3) idle(1, 1);
    end
    idle(2, 0);
    chk("t4_discards", c_discard, 4);
    chk("t4_requests", c_req_rise, 3);
    chk("t4_fails", c_fail, 1);
    chk("t4_max_retry", max_retry_seen, 3);
    chk("t4_errcnt", bus.o_err_frame_cnt, 4);
    chk("t4_busy", bus.o_busy, 0);

    // 5: timeouts with no verdict
    apply_reset();
    drive(1, 1, 1, 1, 0); cycle();
    idle(3 * (TIMEOUT + 1) + 10, 1);
    chk("t5_requests", c_req_rise, 3);
    chk("t5_fails", c_fail, 1);
    chk("t5_discards", c_discard, 1);
    chk("t5_busy", bus.o_busy, 0);

    // 6: async reset while requesting
    apply_reset();
    drive(1, 1, 1, 1, 0); cycle();
    idle(2, 0);
    chk("t6_req_before", bus.o_retrans_req, 1);
    #3;
    i_rst = 1'b0;
    #1;
    chk("t6_req_async", bus.o_retrans_req, 0);
    chk("t6_busy_async", bus.o_busy, 0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    clr_tally();
    drive(0, 1, 0, 0, 0); cycle();
    chk("t6_commit", bus.o_frame_commit, 1);
    chk("t6_retry", bus.o_retry_cnt, 0);

    // Randomized traffic against the model
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
